// File: rtl/gate_share_arbiter.sv
// Round-robin arbiter sharing one registered bitwise gate unit among NREQ requesters.
// Define GATE_ARB_OPSEL_EN to add a per-requester req_op port selecting OR/AND/XOR/NOR.
module gate_share_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int IDW   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
`ifdef GATE_ARB_OPSEL_EN
  input  logic [NREQ*2-1:0]     req_op,
`endif
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [WIDTH-1:0]      res_data,
  output logic [IDW-1:0]        res_id,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state, state_d;
  logic [IDW-1:0]   last_grant, cur_id, win_id, idx;
  logic             win_found;
  logic [WIDTH-1:0] op_a, op_b, gate_out;
  logic [WIDTH-1:0] a_arr [NREQ];
  logic [WIDTH-1:0] b_arr [NREQ];
`ifdef GATE_ARB_OPSEL_EN
  logic [1:0]       op_arr [NREQ];
  logic [1:0]       op_sel;
`endif

  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      a_arr[i] = req_a[i*WIDTH +: WIDTH];
      b_arr[i] = req_b[i*WIDTH +: WIDTH];
`ifdef GATE_ARB_OPSEL_EN
      op_arr[i] = req_op[i*2 +: 2];
`endif
    end
  end

  // Search starts just past the previous winner and wraps modulo NREQ.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    idx       = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = IDW'((32'(last_grant) + k) % 32'(NREQ));
      if (!win_found && req_valid[idx]) begin
        win_found = 1'b1;
        win_id    = idx;
      end
    end
  end

  always_comb begin
    gate_out = op_a | op_b;
`ifdef GATE_ARB_OPSEL_EN
    case (op_sel)
      2'b01:   gate_out = op_a & op_b;
      2'b10:   gate_out = op_a ^ op_b;
      2'b11:   gate_out = ~(op_a | op_b);
      default: gate_out = op_a | op_b;
    endcase
`endif
  end

  // req_ready is qualified by rst_n so no grant is visible while reset is held.
  always_comb begin
    state_d   = state;
    req_ready = '0;
    case (state)
      IDLE: if (win_found && rst_n) begin
        req_ready[win_id] = 1'b1;
        state_d           = EXEC;
      end
      EXEC: state_d = RESP;
      RESP: if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= IDW'(NREQ - 1);
      cur_id     <= '0;
      op_a       <= '0;
      op_b       <= '0;
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_id     <= '0;
`ifdef GATE_ARB_OPSEL_EN
      op_sel     <= '0;
`endif
    end else begin
      state <= state_d;
      case (state)
        IDLE: if (win_found) begin
          op_a   <= a_arr[win_id];
          op_b   <= b_arr[win_id];
          cur_id <= win_id;
`ifdef GATE_ARB_OPSEL_EN
          op_sel <= op_arr[win_id];
`endif
        end
        EXEC: begin
          res_data  <= gate_out;
          res_id    <= cur_id;
          res_valid <= 1'b1;
        end
        RESP: if (res_ready) begin
          res_valid  <= 1'b0;
          last_grant <= cur_id;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_gate_share_arbiter.sv
// Self-checking bench for gate_share_arbiter: directed steps plus random traffic against a behavioural model.
module tb_gate_share_arbiter;
  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int IDW   = 2;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
`ifdef GATE_ARB_OPSEL_EN
  logic [NREQ*2-1:0]     req_op;
`endif
  logic                  res_valid;
  logic                  res_ready;
  logic [WIDTH-1:0]      res_data;
  logic [IDW-1:0]        res_id;
  logic                  busy;

  gate_share_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
`ifdef GATE_ARB_OPSEL_EN
    .req_op(req_op),
`endif
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_id(res_id), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] a_val [NREQ];
  logic [WIDTH-1:0] b_val [NREQ];
  logic [1:0]       op_val [NREQ];
  int model_last;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*WIDTH +: WIDTH] = a_val[i];
      req_b[i*WIDTH +: WIDTH] = b_val[i];
`ifdef GATE_ARB_OPSEL_EN
      req_op[i*2 +: 2] = op_val[i];
`endif
    end
  endtask

  // Winner: first pending requester after the previous winner, wrapping around.
  function automatic int pick(input logic [NREQ-1:0] v, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      int cand = (last + k) % NREQ;
      if (((v >> cand) & 1) != 0) return cand;
    end
    return -1;
  endfunction

  function automatic logic [WIDTH-1:0] expect_result(input int i);
`ifdef GATE_ARB_OPSEL_EN
    case (op_val[i])
      2'b00:   return a_val[i] | b_val[i];
      2'b01:   return a_val[i] & b_val[i];
      2'b10:   return a_val[i] ^ b_val[i];
      default: return ~(a_val[i] | b_val[i]);
    endcase
`else
    return a_val[i] | b_val[i];
`endif
  endfunction

  function automatic void randomize_ops();
    for (int i = 0; i < NREQ; i++) begin
      a_val[i]  = 8'($urandom);
      b_val[i]  = 8'($urandom);
      op_val[i] = 2'($urandom);
    end
  endfunction

  // Entered and left #1 after a rising edge with the DUT idle.
  task automatic do_op(input logic [NREQ-1:0] v, input int hold);
    int w;
    logic [WIDTH-1:0] exp_d;
    req_valid = v;
    drive();
    res_ready = (hold == 0);
    #1;
    w = pick(v, model_last);
    chk("idle_busy", busy, 0);
    if (w < 0) begin
      chk("no_grant", req_ready, 0);
      @(posedge clk); #1;
      chk("stay_idle", busy, 0);
      return;
    end
    chk("grant", req_ready, 32'(1) << w);
    exp_d = expect_result(w);
    @(posedge clk); #1;
    a_val[w] = 8'($urandom);
    b_val[w] = 8'($urandom);
    drive();
    chk("exec_busy", busy, 1);
    chk("exec_ready", req_ready, 0);
    chk("exec_rvalid", res_valid, 0);
    @(posedge clk); #1;
    chk("resp_valid", res_valid, 1);
    chk("resp_data", res_data, exp_d);
    chk("resp_id", res_id, w);
    repeat (hold) begin
      @(posedge clk); #1;
      chk("hold_valid", res_valid, 1);
      chk("hold_data", res_data, exp_d);
      chk("hold_id", res_id, w);
      chk("hold_ready", req_ready, 0);
      chk("hold_busy", busy, 1);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    chk("done_valid", res_valid, 0);
    chk("done_busy", busy, 0);
    model_last = w;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_last = NREQ - 1;
  endtask

  initial begin
    int w;
    rst_n     = 1'b0;
    req_valid = '0;
    res_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      a_val[i] = '0; b_val[i] = '0; op_val[i] = '0;
    end
    drive();
    #2;
    chk("rst_rvalid", res_valid, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_data", res_data, 0);
    chk("rst_id", res_id, 0);
    do_reset();
    repeat (5) begin
      @(posedge clk); #1;
      chk("idle_rvalid", res_valid, 0);
      chk("idle_ready", req_ready, 0);
      chk("idle_busy5", busy, 0);
    end

    a_val[2] = 8'h0F; b_val[2] = 8'hA0; op_val[2] = 2'b00;
    do_op(4'b0100, 0);

    do_reset();
    randomize_ops();
    repeat (8) do_op(4'b1111, 0);

    repeat (3) do_op(4'b0001, 0);

    do_op(4'b1111, 10);
    do_op(4'b1111, 0);

    repeat (40) begin
      randomize_ops();
      do_op(4'($urandom_range(0, 15)), $urandom_range(0, 3));
    end

`ifdef GATE_ARB_OPSEL_EN
    for (int op = 0; op < 4; op++) begin
      a_val[1] = 8'hCC; b_val[1] = 8'hAA; op_val[1] = 2'(op);
      do_op(4'b0010, 0);
    end
`endif

    // Abort while in EXEC; nothing may surface for the discarded request.
    req_valid = 4'b1100;
    res_ready = 1'b1;
    drive();
    #1;
    w = pick(4'b1100, model_last);
    chk("mid_grant", req_ready, 32'(1) << w);
    @(posedge clk); #2;
    chk("mid_exec_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_rvalid", res_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ready", req_ready, 0);
    chk("abort_data", res_data, 0);
    chk("abort_id", res_id, 0);
    @(posedge clk); #1;
    chk("abort_noresult", res_valid, 0);
    req_valid = 4'b1010;
    rst_n = 1'b1;
    model_last = NREQ - 1;
    do_op(4'b1010, 0);
    chk("post_abort_id", res_id, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/gate_share_arbiter.md
Name: gate_share_arbiter

Overview:
- Round-robin arbiter that time-shares one registered bitwise OR unit among NREQ requesters.
- Each requester presents two WIDTH-bit operands with a valid/ready handshake.
- The block grants one requester, captures its operands, evaluates a|b and returns the result with the winner's ID on a single valid/ready response channel.
- Sits between multiple client blocks and the shared gate datapath; it is the only path into that datapath.

Parameters:
- NREQ, 4, number of requesters (2..16).
- WIDTH, 8, operand and result width in bits.
- IDW, 2, width of requester ID; must equal ceil(log2(NREQ)).

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NREQ  bit i: requester i has operands pending.
- req_ready  output  NREQ  one-hot grant; bit i: operands of requester i accepted this cycle.
- req_a  input  NREQ*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- req_b  input  NREQ*WIDTH  operand B; same packing as req_a.
- res_valid  output  1  result and ID valid.
- res_ready  input  1  consumer accepts result.
- res_data  output  WIDTH  registered result.
- res_id  output  IDW  index of the requester that owns res_data.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n). Reset takes effect immediately on the falling edge of rst_n, independent of clk.
- Reset values:
  - state=IDLE, res_valid=0, res_data=0, res_id=0, req_ready=0, busy=0.
  - Round-robin pointer last_grant=NREQ-1, so requester 0 has top priority after reset.
- States: IDLE, EXEC, RESP.
- IDLE:
  - If req_valid is nonzero, combinationally select the first set bit searching last_grant+1, last_grant+2, ... with wrap modulo NREQ.
  - Drive req_ready one-hot for the winner in that same cycle.
  - On the clock edge: capture the winner's req_a and req_b into op_a/op_b, the winner index into cur_id, then go to EXEC.
  - If req_valid is 0: stay in IDLE with req_ready=0.
- EXEC:
  - res_data <= op_a | op_b, res_id <= cur_id, res_valid <= 1, then go to RESP.
  - req_ready=0.
- RESP:
  - Hold res_valid, res_data and res_id stable until res_valid & res_ready.
  - On that handshake edge: res_valid <= 0, last_grant <= cur_id, go to IDLE.
  - req_ready=0 throughout.
- Latency: grant edge to res_valid high = 2 clk edges. Minimum issue interval is 3 cycles per operation.
- Requester rules:
  - A requester holds req_valid and its operands stable until it sees its req_ready bit.
  - Deasserting req_valid before grant is legal; the request is simply dropped.
  - Operand changes after grant do not affect the in-flight result.
- Boundaries:
  - All NREQ valid continuously: grants rotate 0,1,2,...,NREQ-1,0 with no requester skipped or repeated.
  - Single requester valid continuously: it wins every round.
  - Pointer wrap from NREQ-1 to 0 is handled by the modulo search.
  - res_ready already high when res_valid rises: the handshake completes on the first RESP cycle, and IDLE is re-entered on the next edge.
  - res_ready stuck low: the block stays in RESP indefinitely, and no new grant is issued.
  - rst_n asserted mid-operation: the in-flight op is discarded, all outputs go to reset values immediately, and no result is produced for the aborted request.
- busy = (state != IDLE).

Optional Feature:
- Macro: GATE_ARB_OPSEL_EN.
- Defined:
  - Adds input port req_op (NREQ*2 bits, 2 bits per requester), captured with the operands at grant.
  - EXEC computes: 00 -> a|b, 01 -> a&b, 10 -> a^b, 11 -> ~(a|b).
- Undefined:
  - The req_op port does not exist; the datapath is OR only.
  - Behaviour is otherwise identical.

Test Plan:
- Reset then idle: rst_n low 3 cycles, release, all req_valid=0 for 5 cycles -> res_valid=0, req_ready=0, busy=0 throughout.
- Single op: requester 2 valid with a=8'h0F, b=8'hA0, res_ready=1 -> req_ready=4'b0100 in the grant cycle; 2 edges later res_valid=1, res_data=8'hAF, res_id=2; IDLE re-entered on the next edge.
- Fairness: all four valid, res_ready=1, 8 operations -> grant order 0,1,2,3,0,1,2,3; each res_data equals that requester's a|b.
- Backpressure: res_ready=0 for 10 cycles with one result pending -> res_valid, res_data and res_id held constant, req_ready=0 and busy=1 the whole time. Then res_ready=1 -> handshake completes and the next grant follows.
- Reset mid-op: assert rst_n low while in EXEC -> res_valid=0 and busy=0 immediately; after release, the first grant goes to the lowest-index valid requester.
- GATE_ARB_OPSEL_EN build: a=8'hCC, b=8'hAA with op 00/01/10/11 -> results 8'hEE, 8'h88, 8'h66, 8'h11.
